// File: rtl/seg7_pkg.sv
// ============================================================================
// Module   : seg7_pkg
// Brief    : Segment patterns, anode helpers and scan-index type shared by the
//            7-segment display driver and its decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic [1:0] {
        SCAN_0 = 2'd0,
        SCAN_1 = 2'd1,
        SCAN_2 = 2'd2,
        SCAN_3 = 2'd3
    } scan_idx_t;

    function automatic scan_idx_t next_scan(input scan_idx_t s);
        scan_idx_t n;
        case (s)
            SCAN_0:  n = SCAN_1;
            SCAN_1:  n = SCAN_2;
            SCAN_2:  n = SCAN_3;
            default: n = SCAN_0;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] anode_for(input scan_idx_t s);
        logic [3:0] onehot;
        onehot = 4'b0001 << s;
        return ~onehot;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg7.sv
// ============================================================================
// Module   : bcd_to_seg7
// Brief    : Combinational BCD to active-low 7-segment decoder; 10-15 -> dash.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg7_display_driver.sv
// ============================================================================
// Module   : seg7_display_driver
// Brief    : 4-digit multiplexed 7-segment driver with colon and done-blink.
//            Define SEG7_LZ_BLANK_EN to blank a leading zero on digit 3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_display_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter int BLINK_DIV   = 25_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [3:0] sec_1s,
    input  logic [3:0] sec_10s,
    input  logic [3:0] min_1s,
    input  logic [3:0] min_10s,
    input  logic       timer_done,
    input  logic       tick_1Hz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int REFRESH_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_DIV - 1);
    localparam logic [REFRESH_W-1:0] REFRESH_ONE  = REFRESH_W'(1);
    localparam logic [BLINK_W-1:0]   BLINK_LAST   = BLINK_W'(BLINK_DIV - 1);
    localparam logic [BLINK_W-1:0]   BLINK_ONE    = BLINK_W'(1);

    logic [REFRESH_W-1:0] refresh_cnt, refresh_nxt;
    scan_idx_t            scan_idx, scan_nxt;
    logic [3:0][3:0]      snap, snap_nxt;
    logic                 colon, colon_nxt;
    logic [BLINK_W-1:0]   blink_cnt, blink_nxt;
    logic                 blink_on, blink_on_nxt;

    logic                 refresh_wrap;
    logic                 frame_wrap;
    logic [3:0]           digit;
    logic [6:0]           seg_dec;

    logic [3:0]           an_nxt;
    logic [6:0]           seg_nxt;
    logic                 dp_nxt;

    always_comb begin
        refresh_wrap = (refresh_cnt == REFRESH_LAST);
        refresh_nxt  = refresh_wrap ? '0 : refresh_cnt + REFRESH_ONE;
        scan_nxt     = refresh_wrap ? next_scan(scan_idx) : scan_idx;

        // Digits are latched only at the frame boundary so one frame shows one timer value
        frame_wrap   = refresh_wrap && (scan_idx == SCAN_3);
        snap_nxt     = frame_wrap ? {min_10s, min_1s, sec_10s, sec_1s} : snap;

        colon_nxt    = colon ^ tick_1Hz;

        blink_nxt    = '0;
        blink_on_nxt = 1'b1;
        if (timer_done) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_nxt    = '0;
                blink_on_nxt = ~blink_on;
            end else begin
                blink_nxt    = blink_cnt + BLINK_ONE;
                blink_on_nxt = blink_on;
            end
        end

        digit = snap_nxt[scan_nxt];
    end

    bcd_to_seg7 u_decode (
        .bcd (digit),
        .seg (seg_dec)
    );

    // Outputs are built from next state so they register on the same edge as the scan index
    always_comb begin
        an_nxt  = anode_for(scan_nxt);
        seg_nxt = seg_dec;
        dp_nxt  = ~((scan_nxt == SCAN_2) && colon_nxt);

`ifdef SEG7_LZ_BLANK_EN
        if ((scan_nxt == SCAN_3) && (snap_nxt[3] == 4'd0)) begin
            an_nxt  = AN_OFF;
            seg_nxt = SEG_BLANK;
        end
`endif

        if (!blink_on_nxt) begin
            an_nxt = AN_OFF;
            dp_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            scan_idx    <= SCAN_0;
            snap        <= '0;
            colon       <= 1'b0;
            blink_cnt   <= '0;
            blink_on    <= 1'b1;
            an          <= AN_OFF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
        end else begin
            refresh_cnt <= refresh_nxt;
            scan_idx    <= scan_nxt;
            snap        <= snap_nxt;
            colon       <= colon_nxt;
            blink_cnt   <= blink_nxt;
            blink_on    <= blink_on_nxt;
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp          <= dp_nxt;
        end
    end

endmodule

`default_nettype wire
